pad_poller: RTL and testbench

//  Multi-channel serial gamepad controller replacing the single pad_ctrl/button-mock path.

---
 rtl/pad_poller_if.sv | 34 +++
 rtl/pad_poller.sv | 203 ++++++++++++++++++++
 tb/tb_pad_poller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pad_poller_if.sv
// pad_poller_if
//   Host register-bus bundle between the CPU bus arbiter and pad_poller.
//   host_address     3-bit word register index
//   host_read_en     one-cycle read strobe
//   host_write_en    one-cycle write strobe
//   host_write_data  16-bit write data
//   host_read_data   16-bit registered read data
//   host_ready       one-cycle access acknowledge
interface pad_poller_if;
    logic [2:0]  host_address;
    logic        host_read_en;
    logic        host_write_en;
    logic [15:0] host_write_data;
    logic [15:0] host_read_data;
    logic        host_ready;

    modport master (
        output host_address,
        output host_read_en,
        output host_write_en,
        output host_write_data,
        input  host_read_data,
        input  host_ready
    );

    modport slave (
        input  host_address,
        input  host_read_en,
        input  host_write_en,
        input  host_write_data,
        output host_read_data,
        output host_ready
    );
endinterface

// File: rtl/pad_poller.sv
// pad_poller
//   Multi-channel serial gamepad poller. Drives a shared latch/clock pair,
//   shifts BIT_COUNT bits from each of PAD_COUNT pads in parallel and
//   publishes the captured states as read-only registers.
//   Register map (word index): 0 CTRL {start(w1 pulse), auto_en},
//   1 STATUS {done(w1c), busy}, 2+n PAD_STATE[n]; all else reads 0.
// Ports
//   clk           vdp clock, sole clock
//   reset         synchronous, active-high
//   host          register bus (slave side)
//   poll_trigger  frame pulse; starts a poll when auto_en is set
//   pad_latch     shared latch line to the pads
//   pad_clk       shared clock line to the pads
//   pad_data      serial data line from each pad (asynchronous)
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for auto trigger or start write
// S_LATCH  | pad_latch high for 2*CLK_DIV cycles
// S_SETTLE | both lines low CLK_DIV cycles, bit 0 sampled on last cycle
// S_CLK_HI | pad_clk high CLK_DIV cycles
// S_CLK_LO | pad_clk low CLK_DIV cycles, next bit sampled on last cycle
// S_COMMIT | shift registers copied to PAD_STATE, done set
module pad_poller #(
    parameter int PAD_COUNT   = 2,
    parameter int BIT_COUNT   = 16,
    parameter int CLK_DIV     = 24,
    parameter int INVERT_DATA = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pad_poller_if.slave          host,
    input  logic                 poll_trigger,
    output logic                 pad_latch,
    output logic                 pad_clk,
    input  logic [PAD_COUNT-1:0] pad_data
);

    localparam int   TW  = $clog2(2 * CLK_DIV);
    localparam logic INV = (INVERT_DATA != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_SETTLE, S_CLK_HI, S_CLK_LO, S_COMMIT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      bit_q, bit_d;
    logic [15:0]     shift_q [PAD_COUNT];
    logic [15:0]     shift_d [PAD_COUNT];
    logic [15:0]     pad_state_q [PAD_COUNT];
    logic [15:0]     pad_state_d [PAD_COUNT];
    logic            auto_en_q, auto_en_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic [15:0]     rd_data_q, rd_data_d;
    logic [PAD_COUNT-1:0] sync1_q, sync2_q;

    logic wr_ctrl;
    logic start_req;
    logic busy;
    logic unused_wdata;

    assign unused_wdata = ^host.host_write_data[15:2];

    assign busy      = (state_q != S_IDLE);
    assign pad_latch = (state_q == S_LATCH);
    assign pad_clk   = (state_q == S_CLK_HI);

    assign host.host_read_data = rd_data_q;
    assign host.host_ready     = ready_q;

    assign wr_ctrl   = host.host_write_en && (host.host_address == 3'd0);
    assign start_req = (auto_en_q & poll_trigger) | (wr_ctrl & host.host_write_data[1]);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        pad_state_d = pad_state_q;
        auto_en_d   = auto_en_q;
        done_d      = done_q;
        ready_d     = host.host_read_en | host.host_write_en;
        rd_data_d   = '0;

        if (wr_ctrl) begin
            auto_en_d = host.host_write_data[0];
        end
        if (host.host_write_en && (host.host_address == 3'd1) && host.host_write_data[1]) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // requests arriving while busy are simply not looked at
                if (start_req) begin
                    state_d = S_LATCH;
                    timer_d = TW'(2 * CLK_DIV - 1);
                    bit_d   = '0;
                end
            end
            S_LATCH: begin
                if (timer_q == '0) begin
                    state_d = S_SETTLE;
                    timer_d = TW'(CLK_DIV - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    for (int n = 0; n < PAD_COUNT; n++) begin
                        shift_d[n][bit_q] = sync2_q[n] ^ INV;
                    end
                    bit_d   = bit_q + 1'b1;
                    state_d = S_CLK_HI;
                    timer_d = TW'(CLK_DIV - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CLK_HI: begin
                if (timer_q == '0) begin
                    state_d = S_CLK_LO;
                    timer_d = TW'(CLK_DIV - 1);
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_CLK_LO: begin
                if (timer_q == '0) begin
                    for (int n = 0; n < PAD_COUNT; n++) begin
                        shift_d[n][bit_q] = sync2_q[n] ^ INV;
                    end
                    bit_d   = bit_q + 1'b1;
                    timer_d = TW'(CLK_DIV - 1);
                    if (bit_q == 4'(BIT_COUNT - 1)) begin
                        state_d = S_COMMIT;
                    end else begin
                        state_d = S_CLK_HI;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_COMMIT: begin
                // whole-word copy so the host never sees a partial poll;
                // the done set overrides a same-cycle clear
                pad_state_d = shift_q;
                done_d      = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (host.host_read_en) begin
            case (host.host_address)
                3'd0:    rd_data_d = {15'b0, auto_en_q};
                3'd1:    rd_data_d = {14'b0, done_q, busy};
                default: rd_data_d = '0;
            endcase
            for (int n = 0; n < PAD_COUNT; n++) begin
                if (host.host_address == 3'(n + 2)) begin
                    rd_data_d = pad_state_q[n];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_q     <= '0;
            auto_en_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            rd_data_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            for (int n = 0; n < PAD_COUNT; n++) begin
                shift_q[n]     <= '0;
                pad_state_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_q       <= bit_d;
            auto_en_q   <= auto_en_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            rd_data_q   <= rd_data_d;
            sync1_q     <= pad_data;
            sync2_q     <= sync1_q;
            shift_q     <= shift_d;
            pad_state_q <= pad_state_d;
        end
    end

endmodule

// File: tb/tb_pad_poller.sv
module tb_pad_poller;

    localparam int L0 = 3 * 24 + (16 - 1) * 2 * 24 + 1;
    localparam int L6 = 3 * 2 + (12 - 1) * 2 * 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset0 = 1'b1;
    logic       reset6 = 1'b1;
    logic       trig0  = 1'b0;
    logic       trig6  = 1'b0;
    logic       latch0, pclk0, latch6, pclk6;
    logic [1:0] pd0;
    logic [3:0] pd6;

    pad_poller_if bus0 ();
    pad_poller_if bus6 ();

    pad_poller u_dut (
        .clk          (clk),
        .reset        (reset0),
        .host         (bus0),
        .poll_trigger (trig0),
        .pad_latch    (latch0),
        .pad_clk      (pclk0),
        .pad_data     (pd0)
    );

    pad_poller #(.PAD_COUNT(4), .BIT_COUNT(12), .CLK_DIV(2), .INVERT_DATA(0)) u_dut6 (
        .clk          (clk),
        .reset        (reset6),
        .host         (bus6),
        .poll_trigger (trig6),
        .pad_latch    (latch6),
        .pad_clk      (pclk6),
        .pad_data     (pd6)
    );

    // Pad models: parallel-load on latch, advance one bit per pad_clk rise.
    logic [15:0] pat0 [2];
    logic [15:0] snap0 [2];
    logic [15:0] pat6 [4];
    logic [15:0] snap6 [4];
    int   idx0 = 0, idx6 = 0;
    logic pclk0_prev = 1'b0, pclk6_prev = 1'b0, lat_prev0 = 1'b0;
    int   lat_cyc0 = 0, clk_rise0 = 0, polls0 = 0;

    initial begin
        for (int n = 0; n < 2; n++) begin pat0[n] = 16'hFFFF; snap0[n] = 16'hFFFF; end
        for (int n = 0; n < 4; n++) begin pat6[n] = 16'hFFFF; snap6[n] = 16'hFFFF; end
    end

    always @(posedge clk) begin
        pclk0_prev <= pclk0;
        pclk6_prev <= pclk6;
        lat_prev0  <= latch0;
        if (latch0) begin
            for (int n = 0; n < 2; n++) snap0[n] <= pat0[n];
            idx0 <= 0;
        end else if (pclk0 && !pclk0_prev) begin
            idx0 <= idx0 + 1;
        end
        if (latch6) begin
            for (int n = 0; n < 4; n++) snap6[n] <= pat6[n];
            idx6 <= 0;
        end else if (pclk6 && !pclk6_prev) begin
            idx6 <= idx6 + 1;
        end
        if (latch0) lat_cyc0 <= lat_cyc0 + 1;
        if (latch0 && !lat_prev0) polls0 <= polls0 + 1;
        if (pclk0 && !pclk0_prev) clk_rise0 <= clk_rise0 + 1;
    end

    always_comb begin
        pd0 = '1;
        pd6 = '1;
        for (int n = 0; n < 2; n++) pd0[n] = (idx0 < 16) ? snap0[n][idx0[3:0]] : 1'b1;
        for (int n = 0; n < 4; n++) pd6[n] = (idx6 < 16) ? snap6[n][idx6[3:0]] : 1'b1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic rd(input bit sel, input logic [2:0] a, output logic [15:0] d);
        if (sel) begin bus6.host_address = a; bus6.host_read_en = 1'b1; end
        else     begin bus0.host_address = a; bus0.host_read_en = 1'b1; end
        @(posedge clk); #1;
        if (sel) begin
            bus6.host_read_en = 1'b0;
            chk("rd_ready6", 32'(bus6.host_ready), 1);
            d = bus6.host_read_data;
        end else begin
            bus0.host_read_en = 1'b0;
            chk("rd_ready0", 32'(bus0.host_ready), 1);
            d = bus0.host_read_data;
        end
    endtask

    task automatic rdchk(input bit sel, input logic [2:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] d;
        rd(sel, a, d);
        chk16(tag, d, exp);
    endtask

    task automatic wr(input bit sel, input logic [2:0] a, input logic [15:0] v);
        if (sel) begin bus6.host_address = a; bus6.host_write_data = v; bus6.host_write_en = 1'b1; end
        else     begin bus0.host_address = a; bus0.host_write_data = v; bus0.host_write_en = 1'b1; end
        @(posedge clk); #1;
        if (sel) begin
            bus6.host_write_en = 1'b0;
            chk("wr_ready6", 32'(bus6.host_ready), 1);
        end else begin
            bus0.host_write_en = 1'b0;
            chk("wr_ready0", 32'(bus0.host_ready), 1);
        end
    endtask

    int          base_lat, base_rise, base_polls;
    logic [15:0] old0, new0, new1, e16;
    bit          found;

    initial begin
        bus0.host_address = '0; bus0.host_read_en = 1'b0; bus0.host_write_en = 1'b0; bus0.host_write_data = '0;
        bus6.host_address = '0; bus6.host_read_en = 1'b0; bus6.host_write_en = 1'b0; bus6.host_write_data = '0;
        repeat (3) @(posedge clk);
        #1;
        reset0 = 1'b0;
        reset6 = 1'b0;

        // reset state and unmapped reads
        chk("rst_latch", 32'(latch0), 0);
        chk("rst_pclk", 32'(pclk0), 0);
        chk("rst_ready", 32'(bus0.host_ready), 0);
        for (int a = 0; a < 4; a++) rdchk(0, 3'(a), 16'h0000, "rst_reg");
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(bus0.host_ready), 0);
        rdchk(0, 3'd7, 16'h0000, "unmapped7");

        // directed poll with fixed patterns
        pat0[0] = 16'h5A3C;
        pat0[1] = 16'hFFFF;
        base_lat = lat_cyc0; base_rise = clk_rise0; base_polls = polls0;
        wr(0, 3'd0, 16'h0002);
        rdchk(0, 3'd1, 16'h0001, "busy_rise");
        repeat (L0 + 10) @(posedge clk);
        #1;
        chk("latch_cycles", 32'(lat_cyc0 - base_lat), 48);
        chk("clk_pulses", 32'(clk_rise0 - base_rise), 15);
        chk("poll_count", 32'(polls0 - base_polls), 1);
        rdchk(0, 3'd2, 16'hA5C3, "pad0_fixed");
        rdchk(0, 3'd3, 16'h0000, "pad1_fixed");
        rdchk(0, 3'd1, 16'h0002, "done_set");
        rdchk(0, 3'd0, 16'h0000, "ctrl_start_reads0");
        wr(0, 3'd1, 16'h0002);
        rdchk(0, 3'd1, 16'h0000, "done_clear");

        // atomic update: read PAD_STATE0 every cycle across a poll
        old0 = 16'hA5C3;
        pat0[0] = 16'($urandom);
        pat0[1] = 16'($urandom);
        new0 = ~pat0[0];
        new1 = ~pat0[1];
        wr(0, 3'd0, 16'h0002);
        bus0.host_address = 3'd2;
        bus0.host_read_en = 1'b1;
        for (int i = 1; i <= L0 + 3; i++) begin
            @(posedge clk); #1;
            if (i == 400) begin
                pat0[0] = 16'($urandom);
                pat0[1] = 16'($urandom);
            end
            e16 = (i > L0) ? new0 : old0;
            chk16("atomic_pad0", bus0.host_read_data, e16);
        end
        bus0.host_read_en = 1'b0;
        @(posedge clk); #1;
        rdchk(0, 3'd3, new1, "atomic_pad1");
        wr(0, 3'd1, 16'h0002);

        // auto polling on frame pulses; busy-time requests dropped
        wr(0, 3'd0, 16'h0001);
        rdchk(0, 3'd0, 16'h0001, "auto_en_rd");
        for (int p = 0; p < 2; p++) begin
            pat0[0] = 16'($urandom);
            pat0[1] = 16'($urandom);
            new0 = ~pat0[0];
            new1 = ~pat0[1];
            base_polls = polls0; base_lat = lat_cyc0;
            trig0 = 1'b1;
            @(posedge clk); #1;
            trig0 = 1'b0;
            repeat (100) @(posedge clk);
            #1;
            trig0 = 1'b1;
            @(posedge clk); #1;
            trig0 = 1'b0;
            wr(0, 3'd0, 16'h0003);
            repeat (4890) @(posedge clk);
            #1;
            chk("auto_one_poll", 32'(polls0 - base_polls), 1);
            chk("auto_latch_cyc", 32'(lat_cyc0 - base_lat), 48);
            rdchk(0, 3'd2, new0, "auto_pad0");
            rdchk(0, 3'd3, new1, "auto_pad1");
        end
        wr(0, 3'd0, 16'h0000);
        base_polls = polls0;
        trig0 = 1'b1;
        @(posedge clk); #1;
        trig0 = 1'b0;
        repeat (1000) @(posedge clk);
        #1;
        chk("no_auto_poll", 32'(polls0 - base_polls), 0);

        // reset in the middle of a poll
        pat0[0] = 16'($urandom);
        pat0[1] = 16'($urandom);
        base_rise = clk_rise0;
        wr(0, 3'd0, 16'h0002);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (clk_rise0 - base_rise >= 7) begin
                found = 1'b1;
                break;
            end
        end
        chk("reach_bit7", 32'(found), 1);
        reset0 = 1'b1;
        @(posedge clk); #1;
        chk("midrst_latch", 32'(latch0), 0);
        chk("midrst_pclk", 32'(pclk0), 0);
        reset0 = 1'b0;
        rdchk(0, 3'd1, 16'h0000, "midrst_status");
        rdchk(0, 3'd2, 16'h0000, "midrst_pad0");
        rdchk(0, 3'd3, 16'h0000, "midrst_pad1");
        pat0[0] = 16'($urandom);
        pat0[1] = 16'($urandom);
        new0 = ~pat0[0];
        new1 = ~pat0[1];
        base_polls = polls0;
        wr(0, 3'd0, 16'h0002);
        repeat (L0 + 10) @(posedge clk);
        #1;
        chk("post_rst_poll", 32'(polls0 - base_polls), 1);
        rdchk(0, 3'd2, new0, "post_rst_pad0");
        rdchk(0, 3'd3, new1, "post_rst_pad1");
        rdchk(0, 3'd1, 16'h0002, "post_rst_done");

        // four pads, 12 bits, fast clock, raw data
        rdchk(1, 3'd2, 16'h0000, "p6_rst_pad0");
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < 4; n++) pat6[n] = 16'($urandom);
            wr(1, 3'd0, 16'h0002);
            repeat (L6 + 6) @(posedge clk);
            #1;
            for (int n = 0; n < 4; n++) begin
                e16 = pat6[n] & 16'h0FFF;
                rdchk(1, 3'(n + 2), e16, "p6_pad");
            end
            rdchk(1, 3'd6, 16'h0000, "p6_addr6");
            rdchk(1, 3'd1, 16'h0002, "p6_done");
            wr(1, 3'd1, 16'h0002);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
